// File: rtl/grey_code_counter_pkg.sv
// ============================================================================
// Module   : grey_code_counter_pkg
// Purpose  : Width-generic Gray/binary conversion helpers and width limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package grey_code_counter_pkg;

  localparam int c_MAX_WIDTH = 32;

  // Callers zero-extend to c_MAX_WIDTH and truncate the result back.
  function automatic logic [c_MAX_WIDTH-1:0] f_bin2grey(input logic [c_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_MAX_WIDTH-1:0] f_grey2bin(input logic [c_MAX_WIDTH-1:0] g);
    logic [c_MAX_WIDTH-1:0] b;
    b[c_MAX_WIDTH-1] = g[c_MAX_WIDTH-1];
    for (int i = c_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grey_code_counter_if.sv
// ============================================================================
// Module   : grey_code_counter_if
// Purpose  : Control and count bundle of the Gray-code counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grey_code_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_grey;
  logic [WIDTH-1:0] grey;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] grey_next;
  logic             wrap;

  modport master (
    output en, up, load, load_grey,
    input  grey, bin, grey_next, wrap
  );

  modport slave (
    input  en, up, load, load_grey,
    output grey, bin, grey_next, wrap
  );
endinterface

`default_nettype wire

// File: rtl/grey_code_counter_grey2bin_conv.sv
// ============================================================================
// Module   : grey2bin_conv
// Purpose  : Combinational Gray-to-binary prefix-XOR, MSB downwards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grey2bin_conv #(
  parameter int WIDTH = 6
) (
  input  wire logic [WIDTH-1:0] i_grey,
  output logic      [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_grey[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/grey_code_counter.sv
// ============================================================================
// Module   : grey_code_counter
// Purpose  : Up/down loadable Gray counter with registered lookahead and wrap.
//            GREY_CODE_COUNTER_SATURATE_EN turns modulo wrap into saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grey_code_counter
  import grey_code_counter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int INIT  = 0
) (
  input wire logic           clk,
  input wire logic           rst,
  grey_code_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_INIT = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_grey;
  logic [WIDTH-1:0] r_next;
  logic             r_last_up;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_new_bin;
  logic             w_dir;
  logic             w_wrap;

  grey2bin_conv #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .i_grey (bus.load_grey),
    .o_bin  (w_load_bin)
  );

  function automatic logic [WIDTH-1:0] f_to_grey(input logic [WIDTH-1:0] b);
    return WIDTH'(f_bin2grey(c_MAX_WIDTH'(b)));
  endfunction

  function automatic logic f_at_limit(input logic [WIDTH-1:0] b, input logic dir);
    return dir ? (b == c_MAX) : (b == '0);
  endfunction

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] b, input logic dir);
`ifdef GREY_CODE_COUNTER_SATURATE_EN
    if (f_at_limit(b, dir)) begin
      return b;
    end
`endif
    return dir ? b + 1'b1 : b - 1'b1;
  endfunction

  always_comb begin
    w_new_bin = r_bin;
    w_dir     = r_last_up;
    w_wrap    = 1'b0;
    if (bus.load) begin
      w_new_bin = w_load_bin;
      w_dir     = bus.up;
    end else if (bus.en) begin
      w_new_bin = f_step(r_bin, bus.up);
      w_dir     = bus.up;
      w_wrap    = f_at_limit(r_bin, bus.up);
    end
  end

  // Lookahead is computed from the post-update value so a reversal never bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin     <= c_INIT;
      r_grey    <= f_to_grey(c_INIT);
      r_next    <= f_to_grey(f_step(c_INIT, 1'b1));
      r_last_up <= 1'b1;
      r_wrap    <= 1'b0;
    end else begin
      r_bin     <= w_new_bin;
      r_grey    <= f_to_grey(w_new_bin);
      r_next    <= f_to_grey(f_step(w_new_bin, w_dir));
      r_last_up <= w_dir;
      r_wrap    <= w_wrap;
    end
  end

  assign bus.bin       = r_bin;
  assign bus.grey      = r_grey;
  assign bus.grey_next = r_next;
  assign bus.wrap      = r_wrap;

endmodule

`default_nettype wire
